// File: rtl/grid_pkg.sv
// Shared types and boundary helpers for the parametrised grid selection controller.
package grid_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        MARK_X = 2'b01,
        MARK_O = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        FULL
    } state_t;

    function automatic logic [15:0] cell_x0(input int col, input int origin_x, input int cell_w);
        return 16'(origin_x + col * cell_w);
    endfunction

    function automatic logic [15:0] cell_y0(input int row, input int origin_y, input int cell_h);
        return 16'(origin_y + row * cell_h);
    endfunction

endpackage

// File: rtl/grid_pixel_lookup.sv
// Two-stage pixel path: stage 1 locates the cell by constant boundary compares,
// stage 2 reads the board and flags the cursor cell.
module grid_pixel_lookup
    import grid_pkg::*;
#(
    parameter int GRID_COLS = 3,
    parameter int GRID_ROWS = 3,
    parameter int CELL_W    = 160,
    parameter int CELL_H    = 120,
    parameter int ORIGIN_X  = 80,
    parameter int ORIGIN_Y  = 60,
    localparam int N        = GRID_COLS * GRID_ROWS,
    localparam int IW       = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      h_count,
    input  logic [15:0]      v_count,
    input  logic [2*N-1:0]   board,
    input  logic [IW-1:0]    cur,
    output logic [1:0]       pix_cell,
    output logic             pix_cursor
);

    localparam int CLW   = $clog2(GRID_COLS);
    localparam int RWW   = $clog2(GRID_ROWS);
    localparam int X_END = ORIGIN_X + GRID_COLS * CELL_W;
    localparam int Y_END = ORIGIN_Y + GRID_ROWS * CELL_H;

    logic [CLW-1:0] col_c, col_q;
    logic [RWW-1:0] row_c, row_q;
    logic           inside_c, inside_q;
    logic [IW-1:0]  idx;

    // Column/row = number of interior boundaries at or left of (above) the pixel.
    always_comb begin
        col_c = '0;
        row_c = '0;
        for (int c = 1; c < GRID_COLS; c++) begin
            if (h_count >= cell_x0(c, ORIGIN_X, CELL_W)) col_c = col_c + CLW'(1);
        end
        for (int r = 1; r < GRID_ROWS; r++) begin
            if (v_count >= cell_y0(r, ORIGIN_Y, CELL_H)) row_c = row_c + RWW'(1);
        end
        inside_c = (h_count >= 16'(ORIGIN_X)) && (h_count < 16'(X_END)) &&
                   (v_count >= 16'(ORIGIN_Y)) && (v_count < 16'(Y_END));
    end

    always_comb begin
        idx = IW'(int'(row_q) * GRID_COLS + int'(col_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            inside_q   <= 1'b0;
            pix_cell   <= EMPTY;
            pix_cursor <= 1'b0;
        end else begin
            col_q      <= col_c;
            row_q      <= row_c;
            inside_q   <= inside_c;
            pix_cell   <= inside_q ? board[2*idx +: 2] : EMPTY;
            pix_cursor <= inside_q && (idx == cur);
        end
    end

endmodule

// File: rtl/grid_select_ctrl.sv
// Board/cursor controller: edge-detected move/select buttons, optional skip-occupied
// cursor search, alternating X/O placement, cursor rectangle and pixel cell lookup.
module grid_select_ctrl
    import grid_pkg::*;
#(
    parameter int GRID_COLS     = 3,
    parameter int GRID_ROWS     = 3,
    parameter int CELL_W        = 160,
    parameter int CELL_H        = 120,
    parameter int ORIGIN_X      = 80,
    parameter int ORIGIN_Y      = 60,
    parameter int SKIP_OCCUPIED = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Btn,
    input  logic        SelBtn,
    input  logic        clr,
    input  logic [15:0] H_Count_Value,
    input  logic [15:0] V_Count_Value,
    output logic [15:0] startX,
    output logic [15:0] endX,
    output logic [9:0]  startY,
    output logic [9:0]  endY,
    output logic [1:0]  pix_cell,
    output logic        pix_cursor,
    output logic        turn,
    output logic        mark_ok,
    output logic        mark_rej,
    output logic        board_full
);

    localparam int N    = GRID_COLS * GRID_ROWS;
    localparam int IW   = $clog2(N);
    localparam int CNTW = $clog2(N + 1);

    state_t          state, state_n;
    logic [IW-1:0]   cur, cur_n, cand, cand_n;
    logic [CNTW-1:0] cnt, cnt_n;
    logic [2*N-1:0]  board, board_n;
    logic            turn_n, ok_n, rej_n, full_n;
    logic            btn_q, sel_q, move_edge, sel_edge;
    int              cur_col, cur_row;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(N - 1)) ? '0 : i + IW'(1);
    endfunction

    function automatic logic [1:0] cell_at(input logic [2*N-1:0] b, input logic [IW-1:0] i);
        return b[2*i +: 2];
    endfunction

    function automatic logic all_marked(input logic [2*N-1:0] b);
        logic full;
        full = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (b[2*i +: 2] == EMPTY) full = 1'b0;
        end
        return full;
    endfunction

    assign move_edge = Btn & ~btn_q;
    assign sel_edge  = SelBtn & ~sel_q;

    // Next-state logic: select beats move, clr overrides everything but reset.
    always_comb begin
        state_n = state;
        cur_n   = cur;
        cand_n  = cand;
        cnt_n   = cnt;
        turn_n  = turn;
        board_n = board;
        ok_n    = 1'b0;
        rej_n   = 1'b0;
        case (state)
            IDLE: begin
                if (sel_edge) begin
                    if (cell_at(board, cur) == EMPTY) begin
                        board_n[2*cur +: 2] = turn ? MARK_O : MARK_X;
                        turn_n = ~turn;
                        ok_n   = 1'b1;
                    end else begin
                        rej_n = 1'b1;
                    end
                end else if (move_edge) begin
                    if (SKIP_OCCUPIED != 0) begin
                        state_n = SEARCH;
                        cand_n  = next_idx(cur);
                        cnt_n   = CNTW'(1);
                    end else begin
                        cur_n = next_idx(cur);
                    end
                end
            end
            SEARCH: begin
                rej_n = sel_edge;
                if (cell_at(board, cand) == EMPTY) begin
                    cur_n   = cand;
                    state_n = IDLE;
                end else if (cnt == CNTW'(N)) begin
                    state_n = FULL;
                end else begin
                    cand_n = next_idx(cand);
                    cnt_n  = cnt + CNTW'(1);
                end
            end
            FULL: begin
                rej_n = sel_edge;
            end
            default: state_n = IDLE;
        endcase
        full_n = all_marked(board_n);
        if (full_n) state_n = FULL;
        if (clr) begin
            state_n = IDLE;
            cur_n   = '0;
            cand_n  = '0;
            cnt_n   = '0;
            turn_n  = 1'b0;
            board_n = '0;
            ok_n    = 1'b0;
            rej_n   = 1'b0;
            full_n  = 1'b0;
        end
    end

    always_comb begin
        cur_col = int'(cur) % GRID_COLS;
        cur_row = int'(cur) / GRID_COLS;
    end

    // Bounds follow the registered cursor, so they lag a cursor change by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur        <= '0;
            cand       <= '0;
            cnt        <= '0;
            turn       <= 1'b0;
            board      <= '0;
            mark_ok    <= 1'b0;
            mark_rej   <= 1'b0;
            board_full <= 1'b0;
            btn_q      <= 1'b0;
            sel_q      <= 1'b0;
            startX     <= cell_x0(0, ORIGIN_X, CELL_W);
            endX       <= cell_x0(0, ORIGIN_X, CELL_W) + 16'(CELL_W - 1);
            startY     <= 10'(cell_y0(0, ORIGIN_Y, CELL_H));
            endY       <= 10'(cell_y0(0, ORIGIN_Y, CELL_H) + 16'(CELL_H - 1));
        end else begin
            state      <= state_n;
            cur        <= cur_n;
            cand       <= cand_n;
            cnt        <= cnt_n;
            turn       <= turn_n;
            board      <= board_n;
            mark_ok    <= ok_n;
            mark_rej   <= rej_n;
            board_full <= full_n;
            btn_q      <= Btn;
            sel_q      <= SelBtn;
            startX     <= cell_x0(cur_col, ORIGIN_X, CELL_W);
            endX       <= cell_x0(cur_col, ORIGIN_X, CELL_W) + 16'(CELL_W - 1);
            startY     <= 10'(cell_y0(cur_row, ORIGIN_Y, CELL_H));
            endY       <= 10'(cell_y0(cur_row, ORIGIN_Y, CELL_H) + 16'(CELL_H - 1));
        end
    end

    grid_pixel_lookup #(
        .GRID_COLS (GRID_COLS),
        .GRID_ROWS (GRID_ROWS),
        .CELL_W    (CELL_W),
        .CELL_H    (CELL_H),
        .ORIGIN_X  (ORIGIN_X),
        .ORIGIN_Y  (ORIGIN_Y)
    ) u_pixel (
        .clk        (clk),
        .rst        (rst),
        .h_count    (H_Count_Value),
        .v_count    (V_Count_Value),
        .board      (board),
        .cur        (cur),
        .pix_cell   (pix_cell),
        .pix_cursor (pix_cursor)
    );

endmodule

// File: tb/tb_grid_select_ctrl.sv
// Directed bench for grid_select_ctrl (3x3, skip-occupied): reset, marking, search,
// simultaneous edges, full board with clear, and the pixel lookup path.
module tb_grid_select_ctrl;
    import grid_pkg::*;

    logic        clk = 1'b0;
    logic        rst, Btn, SelBtn, clr;
    logic [15:0] H_Count_Value, V_Count_Value;
    logic [15:0] startX, endX;
    logic [9:0]  startY, endY;
    logic [1:0]  pix_cell;
    logic        pix_cursor, turn, mark_ok, mark_rej, board_full;
    int          checks = 0;
    int          errors = 0;

    always #20 clk = ~clk;

    grid_select_ctrl #(
        .GRID_COLS(3), .GRID_ROWS(3), .CELL_W(160), .CELL_H(120),
        .ORIGIN_X(80), .ORIGIN_Y(60), .SKIP_OCCUPIED(1)
    ) dut (
        .clk(clk), .rst(rst), .Btn(Btn), .SelBtn(SelBtn), .clr(clr),
        .H_Count_Value(H_Count_Value), .V_Count_Value(V_Count_Value),
        .startX(startX), .endX(endX), .startY(startY), .endY(endY),
        .pix_cell(pix_cell), .pix_cursor(pix_cursor), .turn(turn),
        .mark_ok(mark_ok), .mark_rej(mark_rej), .board_full(board_full)
    );

    // Raise the requested levels for one cycle; returns on the negedge after the edge is seen.
    task automatic pulse(input logic sel, input logic mv);
        @(negedge clk);
        SelBtn = sel;
        Btn    = mv;
        @(negedge clk);
        SelBtn = 1'b0;
        Btn    = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    // Move with a one-candidate search, then settle back in IDLE.
    task automatic move_one();
        pulse(1'b0, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; Btn = 1'b0; SelBtn = 1'b0; clr = 1'b0;
        H_Count_Value = 16'd0; V_Count_Value = 16'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (startX !== 16'd80) begin errors++; $display("[TB] FAIL reset_startX: got %0d expected 80", startX); end
        checks++; if (endX !== 16'd239) begin errors++; $display("[TB] FAIL reset_endX: got %0d expected 239", endX); end
        checks++; if (startY !== 10'd60) begin errors++; $display("[TB] FAIL reset_startY: got %0d expected 60", startY); end
        checks++; if (endY !== 10'd179) begin errors++; $display("[TB] FAIL reset_endY: got %0d expected 179", endY); end
        checks++; if (turn !== 1'b0) begin errors++; $display("[TB] FAIL reset_turn: got %b expected 0", turn); end
        checks++; if (pix_cell !== 2'b00) begin errors++; $display("[TB] FAIL reset_pix_cell: got %b expected 00", pix_cell); end
        checks++; if (pix_cursor !== 1'b0) begin errors++; $display("[TB] FAIL reset_pix_cursor: got %b expected 0", pix_cursor); end
        checks++; if ({mark_ok, mark_rej, board_full} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {mark_ok, mark_rej, board_full}); end
    endtask

    task automatic test_select();
        pulse(1'b1, 1'b0);
        checks++; if (mark_ok !== 1'b1) begin errors++; $display("[TB] FAIL sel_mark_ok: got %b expected 1", mark_ok); end
        checks++; if (mark_rej !== 1'b0) begin errors++; $display("[TB] FAIL sel_mark_rej: got %b expected 0", mark_rej); end
        checks++; if (turn !== 1'b1) begin errors++; $display("[TB] FAIL sel_turn: got %b expected 1", turn); end
        checks++; if (dut.board[1:0] !== 2'b01) begin errors++; $display("[TB] FAIL sel_cell0: got %b expected 01", dut.board[1:0]); end
        @(negedge clk);
        checks++; if (mark_ok !== 1'b0) begin errors++; $display("[TB] FAIL sel_ok_one_cycle: got %b expected 0", mark_ok); end
        pulse(1'b1, 1'b0);
        checks++; if (mark_rej !== 1'b1) begin errors++; $display("[TB] FAIL resel_mark_rej: got %b expected 1", mark_rej); end
        checks++; if (mark_ok !== 1'b0) begin errors++; $display("[TB] FAIL resel_mark_ok: got %b expected 0", mark_ok); end
        checks++; if (turn !== 1'b1) begin errors++; $display("[TB] FAIL resel_turn: got %b expected 1", turn); end
        checks++; if (dut.board[1:0] !== 2'b01) begin errors++; $display("[TB] FAIL resel_cell0: got %b expected 01", dut.board[1:0]); end
    endtask

    task automatic test_search();
        do_clear();
        for (int i = 1; i <= 3; i++) begin
            move_one();
            pulse(1'b1, 1'b0);
        end
        for (int i = 0; i < 6; i++) move_one();
        checks++; if (dut.cur !== 4'd0) begin errors++; $display("[TB] FAIL search_setup_cur: got %0d expected 0", dut.cur); end
        pulse(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++; if (dut.state !== SEARCH) begin errors++; $display("[TB] FAIL search_state_%0d: got %0d expected %0d", i, dut.state, SEARCH); end
        end
        @(negedge clk);
        checks++; if (dut.state !== IDLE) begin errors++; $display("[TB] FAIL search_done_state: got %0d expected %0d", dut.state, IDLE); end
        checks++; if (dut.cur !== 4'd4) begin errors++; $display("[TB] FAIL search_cur: got %0d expected 4", dut.cur); end
        @(negedge clk);
        checks++; if (startX !== 16'd240) begin errors++; $display("[TB] FAIL search_startX: got %0d expected 240", startX); end
        checks++; if (endX !== 16'd399) begin errors++; $display("[TB] FAIL search_endX: got %0d expected 399", endX); end
        checks++; if (startY !== 10'd180) begin errors++; $display("[TB] FAIL search_startY: got %0d expected 180", startY); end
        checks++; if (endY !== 10'd299) begin errors++; $display("[TB] FAIL search_endY: got %0d expected 299", endY); end
    endtask

    task automatic test_simultaneous();
        do_clear();
        move_one();
        move_one();
        pulse(1'b1, 1'b1);
        checks++; if (mark_ok !== 1'b1) begin errors++; $display("[TB] FAIL simul_mark_ok: got %b expected 1", mark_ok); end
        checks++; if (dut.board[5:4] !== 2'b01) begin errors++; $display("[TB] FAIL simul_cell2: got %b expected 01", dut.board[5:4]); end
        @(negedge clk);
        checks++; if (dut.cur !== 4'd2) begin errors++; $display("[TB] FAIL simul_cur: got %0d expected 2", dut.cur); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("[TB] FAIL simul_state: got %0d expected %0d", dut.state, IDLE); end
    endtask

    task automatic test_full();
        logic [17:0] exp_board;
        exp_board = '0;
        do_clear();
        for (int i = 0; i < 9; i++) begin
            pulse(1'b1, 1'b0);
            exp_board[2*i +: 2] = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (mark_ok !== 1'b1) begin errors++; $display("[TB] FAIL fill_ok_%0d: got %b expected 1", i, mark_ok); end
            if (i < 8) begin
                checks++; if (board_full !== 1'b0) begin errors++; $display("[TB] FAIL fill_early_full_%0d: got %b expected 0", i, board_full); end
                move_one();
            end
        end
        checks++; if (board_full !== 1'b1) begin errors++; $display("[TB] FAIL full_flag: got %b expected 1", board_full); end
        checks++; if (dut.state !== FULL) begin errors++; $display("[TB] FAIL full_state: got %0d expected %0d", dut.state, FULL); end
        checks++; if (dut.board !== exp_board) begin errors++; $display("[TB] FAIL full_board: got %h expected %h", dut.board, exp_board); end
        checks++; if (startY !== 10'd300) begin errors++; $display("[TB] FAIL full_startY: got %0d expected 300", startY); end
        pulse(1'b0, 1'b1);
        repeat (2) @(negedge clk);
        checks++; if (dut.cur !== 4'd8) begin errors++; $display("[TB] FAIL full_move_cur: got %0d expected 8", dut.cur); end
        checks++; if (dut.state !== FULL) begin errors++; $display("[TB] FAIL full_move_state: got %0d expected %0d", dut.state, FULL); end
        pulse(1'b1, 1'b0);
        checks++; if (mark_rej !== 1'b1) begin errors++; $display("[TB] FAIL full_sel_rej: got %b expected 1", mark_rej); end
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++; if (dut.board !== 18'd0) begin errors++; $display("[TB] FAIL clr_board: got %h expected 0", dut.board); end
        checks++; if (dut.cur !== 4'd0) begin errors++; $display("[TB] FAIL clr_cur: got %0d expected 0", dut.cur); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("[TB] FAIL clr_state: got %0d expected %0d", dut.state, IDLE); end
        checks++; if ({board_full, turn} !== 2'b00) begin errors++; $display("[TB] FAIL clr_full_turn: got %b expected 00", {board_full, turn}); end
        @(negedge clk);
        checks++; if (startX !== 16'd80) begin errors++; $display("[TB] FAIL clr_startX: got %0d expected 80", startX); end
    endtask

    task automatic test_pixel();
        int          hs[8] = '{250, 10, 240, 239, 399, 400, 559, 560};
        int          vs[8] = '{70, 10, 60, 60, 179, 179, 419, 419};
        logic [1:0]  ec[8] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        logic        eu[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        do_clear();
        move_one();
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            H_Count_Value = 16'(hs[i]);
            V_Count_Value = 16'(vs[i]);
            repeat (2) @(negedge clk);
            checks++; if (pix_cell !== ec[i]) begin errors++; $display("[TB] FAIL pix_cell_%0d_%0d: got %b expected %b", hs[i], vs[i], pix_cell, ec[i]); end
            checks++; if (pix_cursor !== eu[i]) begin errors++; $display("[TB] FAIL pix_cursor_%0d_%0d: got %b expected %b", hs[i], vs[i], pix_cursor, eu[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_select();
        test_search();
        test_simultaneous();
        test_full();
        test_pixel();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
